// File: rtl/sea_round_core.sv
// Iterative SEA-style Feistel core: one round per clock on an N-bit block,
// with an on-the-fly key schedule that runs forwards (encrypt) or backwards (decrypt).
module sea_round_core #(
  parameter int N  = 256,
  parameter int B  = 8,
  parameter int NR = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [N-1:0]     data_in,
  input  logic [N/2-1:0]   key_in,
  output logic             ready,
  output logic             done,
  output logic [N-1:0]     data_out,
  output logic [N/2-1:0]   key_out
);

  localparam int H = N / 2;
  localparam int W = H / B;
  localparam int T = W / 3;

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state_reg, state_next;
  logic [H-1:0]   l_reg, r_reg, key_reg;
  logic           mode_reg;
  logic [7:0]     cnt_reg;
  logic           done_reg;
  logic [N-1:0]   data_out_reg;
  logic [H-1:0]   key_out_reg;

  logic           accept, finish, last_round;
  logic [H-1:0]   f_in, sum_w, f_out;
  logic [H-1:0]   l_next, r_next, key_next;

  function automatic logic [2:0] sbox(input logic [2:0] v);
    logic [2:0] s;
    case (v)
      3'd0:    s = 3'd0;
      3'd1:    s = 3'd5;
      3'd2:    s = 3'd6;
      3'd3:    s = 3'd7;
      3'd4:    s = 3'd4;
      3'd5:    s = 3'd3;
      3'd6:    s = 3'd1;
      default: s = 3'd2;
    endcase
    return s;
  endfunction

  function automatic logic [B-1:0] rotr1(input logic [B-1:0] x);
    return (x >> 1) | (x << (B - 1));
  endfunction

  function automatic logic [B-1:0] rotl1(input logic [B-1:0] x);
    return (x << 1) | (x >> (B - 1));
  endfunction

  // Whole-word rotations of a half; shift form keeps W=1 well defined.
  function automatic logic [H-1:0] rotl_w(input logic [H-1:0] x);
    return (x << B) | (x >> (H - B));
  endfunction

  function automatic logic [H-1:0] rotr_w(input logic [H-1:0] x);
    return (x >> B) | (x << (H - B));
  endfunction

  // Encrypt feeds R into F, decrypt feeds the incoming L' (which was R).
  assign f_in = mode_reg ? l_reg : r_reg;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_add
      assign sum_w[gi*B +: B] = f_in[gi*B +: B] + key_reg[gi*B +: B];
    end

    for (genvar gi = 0; gi < T; gi++) begin : g_triple
      logic [B-1:0] s0, s1, s2;
      for (genvar gk = 0; gk < B; gk++) begin : g_bit
        logic [2:0] sv;
        assign sv = sbox({sum_w[(3*gi+2)*B + gk], sum_w[(3*gi+1)*B + gk], sum_w[3*gi*B + gk]});
        assign s0[gk] = sv[0];
        assign s1[gk] = sv[1];
        assign s2[gk] = sv[2];
      end
      assign f_out[3*gi*B     +: B] = rotr1(s0);
      assign f_out[(3*gi+1)*B +: B] = s1;
      assign f_out[(3*gi+2)*B +: B] = rotl1(s2);
    end

    // Words past the last full triple skip S and BR entirely.
    for (genvar gi = 3*T; gi < W; gi++) begin : g_bypass
      assign f_out[gi*B +: B] = sum_w[gi*B +: B];
    end
  endgenerate

  always_comb begin
    l_next   = r_reg;
    r_next   = rotl_w(l_reg ^ f_out);
    key_next = rotl_w(key_reg) ^ H'(cnt_reg);
    if (mode_reg) begin
      r_next   = l_reg;
      l_next   = rotr_w(r_reg) ^ f_out;
      key_next = rotr_w(key_reg ^ H'(cnt_reg - 8'd1));
    end
  end

  assign last_round = mode_reg ? (cnt_reg == 8'd0) : (cnt_reg == 8'(NR - 1));

  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_round) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      l_reg        <= '0;
      r_reg        <= '0;
      key_reg      <= '0;
      mode_reg     <= 1'b0;
      cnt_reg      <= '0;
      done_reg     <= 1'b0;
      data_out_reg <= '0;
      key_out_reg  <= '0;
    end else begin
      done_reg <= finish;
      if (accept) begin
        l_reg    <= data_in[N-1:H];
        r_reg    <= data_in[H-1:0];
        key_reg  <= key_in;
        mode_reg <= mode;
        cnt_reg  <= mode ? 8'(NR - 1) : 8'd0;
      end else if (state_reg == RUN) begin
        l_reg   <= l_next;
        r_reg   <= r_next;
        key_reg <= key_next;
        cnt_reg <= mode_reg ? cnt_reg - 8'd1 : cnt_reg + 8'd1;
        // key_out reports the key used by the final round, not the next step.
        if (finish) begin
          data_out_reg <= {l_next, r_next};
          key_out_reg  <= key_reg;
        end
      end
    end
  end

  assign ready    = (state_reg == IDLE);
  assign done     = done_reg;
  assign data_out = data_out_reg;
  assign key_out  = key_out_reg;

endmodule

// File: tb/tb_sea_round_core.sv
// Self-checking bench for sea_round_core: four instances of different geometry,
// a word-array reference model, constant vectors and handshake corner sequences.
module tb_sea_round_core;

  localparam int NI  = 4;
  localparam int N0  = 256;
  localparam int N1  = 96;
  localparam int N2  = 80;
  localparam int N3  = 64;
  localparam int NR0 = 16;
  localparam int NR1 = 16;
  localparam int NR2 = 5;
  localparam int NR3 = 1;

  logic clk;
  logic rst;
  logic         start_v [NI];
  logic         mode_v  [NI];
  logic [255:0] din_v   [NI];
  logic [127:0] kin_v   [NI];
  logic [NI-1:0] ready_v;
  logic [NI-1:0] done_v;
  logic [N0-1:0] dout0;
  logic [N1-1:0] dout1;
  logic [N2-1:0] dout2;
  logic [N3-1:0] dout3;
  logic [N0/2-1:0] kout0;
  logic [N1/2-1:0] kout1;
  logic [N2/2-1:0] kout2;
  logic [N3/2-1:0] kout3;

  int checks;
  int failures;

  sea_round_core #(.N(N0), .B(8), .NR(NR0)) u_dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .mode(mode_v[0]),
    .data_in(din_v[0][N0-1:0]), .key_in(kin_v[0][N0/2-1:0]),
    .ready(ready_v[0]), .done(done_v[0]), .data_out(dout0), .key_out(kout0));

  sea_round_core #(.N(N1), .B(8), .NR(NR1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .mode(mode_v[1]),
    .data_in(din_v[1][N1-1:0]), .key_in(kin_v[1][N1/2-1:0]),
    .ready(ready_v[1]), .done(done_v[1]), .data_out(dout1), .key_out(kout1));

  sea_round_core #(.N(N2), .B(8), .NR(NR2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .mode(mode_v[2]),
    .data_in(din_v[2][N2-1:0]), .key_in(kin_v[2][N2/2-1:0]),
    .ready(ready_v[2]), .done(done_v[2]), .data_out(dout2), .key_out(kout2));

  sea_round_core #(.N(N3), .B(8), .NR(NR3)) u_dut3 (
    .clk(clk), .rst(rst), .start(start_v[3]), .mode(mode_v[3]),
    .data_in(din_v[3][N3-1:0]), .key_in(kin_v[3][N3/2-1:0]),
    .ready(ready_v[3]), .done(done_v[3]), .data_out(dout3), .key_out(kout3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int n_of(input int id);
    case (id)
      0: return N0;
      1: return N1;
      2: return N2;
      default: return N3;
    endcase
  endfunction

  function automatic int nr_of(input int id);
    case (id)
      0: return NR0;
      1: return NR1;
      2: return NR2;
      default: return NR3;
    endcase
  endfunction

  function automatic logic [255:0] get_dout(input int id);
    case (id)
      0: return dout0;
      1: return 256'(dout1);
      2: return 256'(dout2);
      default: return 256'(dout3);
    endcase
  endfunction

  function automatic logic [127:0] get_kout(input int id);
    case (id)
      0: return kout0;
      1: return 128'(kout1);
      2: return 128'(kout2);
      default: return 128'(kout3);
    endcase
  endfunction

  // Reference model: a half is a list of 8-bit words, word 0 least significant.
  typedef logic [7:0] words_t [16];

  function automatic words_t to_w(input logic [127:0] h);
    words_t r;
    for (int j = 0; j < 16; j++) r[j] = h[j*8 +: 8];
    return r;
  endfunction

  function automatic logic [127:0] from_w(input words_t x, input int w);
    logic [127:0] h;
    h = '0;
    for (int j = 0; j < w; j++) h[j*8 +: 8] = x[j];
    return h;
  endfunction

  function automatic words_t xor_w(input words_t a, input words_t b);
    words_t r;
    for (int j = 0; j < 16; j++) r[j] = a[j] ^ b[j];
    return r;
  endfunction

  function automatic words_t wr(input words_t x, input int w);
    words_t y;
    y = x;
    for (int j = 0; j < w; j++) y[(j + 1) % w] = x[j];
    return y;
  endfunction

  function automatic words_t wr_inv(input words_t x, input int w);
    words_t y;
    y = x;
    for (int j = 0; j < w; j++) y[j] = x[(j + 1) % w];
    return y;
  endfunction

  function automatic words_t f_model(input words_t r, input words_t k, input int w);
    words_t a;
    int sb [8] = '{0, 5, 6, 7, 4, 3, 1, 2};
    logic [2:0] s;
    int v;
    for (int j = 0; j < 16; j++) a[j] = r[j] + k[j];
    for (int t = 0; t < w / 3; t++) begin
      for (int b = 0; b < 8; b++) begin
        v = int'({a[3*t+2][b], a[3*t+1][b], a[3*t][b]});
        s = 3'(sb[v]);
        a[3*t][b]   = s[0];
        a[3*t+1][b] = s[1];
        a[3*t+2][b] = s[2];
      end
      a[3*t]   = {a[3*t][0], a[3*t][7:1]};
      a[3*t+2] = {a[3*t+2][6:0], a[3*t+2][7]};
    end
    return a;
  endfunction

  task automatic model_run(input int n, input int nrr, input bit md,
                           input logic [255:0] d, input logic [127:0] k,
                           output logic [255:0] dout, output logic [127:0] kout);
    int w;
    int h;
    words_t l, r, kk, f, t;
    w = n / 16;
    h = n / 2;
    l  = to_w(128'(d >> h) & ((128'd1 << h) - 1));
    r  = to_w(d[127:0] & ((128'd1 << h) - 1));
    kk = to_w(k);
    kout = '0;
    if (!md) begin
      for (int i = 0; i < nrr; i++) begin
        f = f_model(r, kk, w);
        t = r;
        r = wr(xor_w(l, f), w);
        l = t;
        kout = from_w(kk, w);
        kk = wr(kk, w);
        kk[0] = kk[0] ^ 8'(i);
      end
    end else begin
      for (int i = nrr - 1; i >= 0; i--) begin
        f = f_model(l, kk, w);
        t = l;
        l = xor_w(wr_inv(r, w), f);
        r = t;
        kout = from_w(kk, w);
        if (i > 0) begin
          kk[0] = kk[0] ^ 8'(i - 1);
          kk = wr_inv(kk, w);
        end
      end
    end
    dout = (256'(from_w(l, w)) << h) | 256'(from_w(r, w));
  endtask

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One full transaction; mode is flipped right after accept to prove it is latched.
  task automatic op(input int id, input bit md, input logic [255:0] d, input logic [127:0] k,
                    output logic [255:0] dout, output logic [127:0] kout, output int lat);
    int guard;
    @(negedge clk);
    guard = 0;
    while (!ready_v[id] && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    start_v[id] = 1'b1;
    mode_v[id]  = md;
    din_v[id]   = d;
    kin_v[id]   = k;
    @(posedge clk);
    #1;
    start_v[id] = 1'b0;
    mode_v[id]  = ~md;
    chk("ready_low_after_accept", 256'(ready_v[id]), 256'd0);
    lat = 0;
    while (!done_v[id] && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("ready_at_done", 256'(ready_v[id]), 256'd1);
    dout = get_dout(id);
    kout = get_kout(id);
    $display("op id=%0d mode=%0d lat=%0d data_out=%h key_out=%h", id, md, lat, dout, kout);
  endtask

  typedef struct {
    int           id;
    bit           md;
    logic [255:0] d;
    logic [127:0] k;
    logic [255:0] ed;
    logic [127:0] ek;
  } vec_t;

  function automatic logic [255:0] rand_bits(input int nbits);
    logic [255:0] x;
    for (int j = 0; j < 8; j++) x[j*32 +: 32] = $urandom;
    return x & ((256'd1 << nbits) - 1);
  endfunction

  initial begin
    vec_t tab [$];
    vec_t v;
    logic [255:0] dout, mdout, pt, d2;
    logic [127:0] kout, mkout, k0, kout2;
    int lat, ndone, first, guard;

    checks = 0;
    failures = 0;
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin
      start_v[i] = 1'b0;
      mode_v[i]  = 1'b0;
      din_v[i]   = '0;
      kin_v[i]   = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("reset_ready", 256'(ready_v[i]), 256'd1);
      chk("reset_done", 256'(done_v[i]), 256'd0);
      chk("reset_data_out", get_dout(i), 256'd0);
      chk("reset_key_out", 256'(get_kout(i)), 256'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Constant vectors on the N=64 / NR=1 core, then model-derived vectors.
    tab.push_back('{3, 1'b0, 256'h0, 128'h0, 256'h0, 128'h0});
    tab.push_back('{3, 1'b0, 256'h0000_0000_FFFF_FFFF, 128'h0101_0101,
                    256'hFFFF_FFFF_0000_0000, 128'h0101_0101});
    tab.push_back('{3, 1'b0, 256'h0000_0000_0000_00FF, 128'h0000_0001,
                    256'h0000_00FF_0000_0000, 128'h0000_0001});
    tab.push_back('{3, 1'b0, 256'h0, 128'h0000_0001, 256'h0000_0000_0200_8000, 128'h0000_0001});
    tab.push_back('{3, 1'b1, 256'h0000_0000_0200_8000, 128'h0000_0001, 256'h0, 128'h0000_0001});
    v = '{2, 1'b0, (256'd1 << N2) - 1, (128'd1 << (N2/2)) - 1, '0, '0};
    tab.push_back(v);
    v = '{2, 1'b0, 256'h00FF_00FF_00FF_00FF_00FF, 128'h01_0001_0001, '0, '0};
    tab.push_back(v);
    v = '{0, 1'b0, {128'h0, {16{8'hFF}}}, {16{8'h01}}, '0, '0};
    tab.push_back(v);
    v = '{1, 1'b1, 256'h1234_5678_9ABC_DEF0_0F1E_2D3C, 128'hA5A5_5A5A_C3C3, '0, '0};
    tab.push_back(v);
    for (int i = 5; i < tab.size(); i++) begin
      model_run(n_of(tab[i].id), nr_of(tab[i].id), tab[i].md, tab[i].d, tab[i].k, mdout, mkout);
      tab[i].ed = mdout;
      tab[i].ek = mkout;
    end
    for (int i = 0; i < tab.size(); i++) begin
      op(tab[i].id, tab[i].md, tab[i].d, tab[i].k, dout, kout, lat);
      chk($sformatf("vec%0d_data", i), dout, tab[i].ed);
      chk($sformatf("vec%0d_key", i), 256'(kout), 256'(tab[i].ek));
      chk($sformatf("vec%0d_latency", i), 256'(lat), 256'(nr_of(tab[i].id)));
    end

    // Random encrypt against the model, then decrypt back to the plaintext.
    for (int id = 0; id < NI; id++) begin
      for (int r = 0; r < ((id < 2) ? 100 : 30); r++) begin
        pt = rand_bits(n_of(id));
        k0 = 128'(rand_bits(n_of(id) / 2));
        model_run(n_of(id), nr_of(id), 1'b0, pt, k0, mdout, mkout);
        op(id, 1'b0, pt, k0, dout, kout, lat);
        chk("rand_enc_data", dout, mdout);
        chk("rand_enc_key", 256'(kout), 256'(mkout));
        chk("rand_enc_latency", 256'(lat), 256'(nr_of(id)));
        op(id, 1'b1, dout, kout, d2, kout2, lat);
        chk("rand_dec_plain", d2, pt);
        chk("rand_dec_key", 256'(kout2), 256'(k0));
      end
    end

    // start held high through RUN: one done at NR, re-accept in the done cycle.
    pt = rand_bits(N0);
    k0 = 128'(rand_bits(N0 / 2));
    model_run(N0, NR0, 1'b0, pt, k0, mdout, mkout);
    @(negedge clk);
    start_v[0] = 1'b1;
    mode_v[0]  = 1'b0;
    din_v[0]   = pt;
    kin_v[0]   = k0;
    @(posedge clk);
    #1;
    ndone = 0;
    first = -1;
    for (int c = 1; c <= NR0; c++) begin
      @(posedge clk);
      #1;
      if (done_v[0]) begin
        ndone++;
        if (first < 0) first = c;
      end
    end
    chk("burst_done_count", 256'(ndone), 256'd1);
    chk("burst_done_cycle", 256'(first), 256'(NR0));
    chk("burst_ready_at_done", 256'(ready_v[0]), 256'd1);
    chk("burst_first_data", get_dout(0), mdout);
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    chk("burst_reaccept_ready", 256'(ready_v[0]), 256'd0);
    chk("burst_reaccept_done", 256'(done_v[0]), 256'd0);
    lat = 0;
    while (!done_v[0] && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("burst_second_latency", 256'(lat), 256'(NR0));
    chk("burst_second_data", get_dout(0), mdout);
    $display("burst id=0 dones=%0d first=%0d second_lat=%0d", ndone, first, lat);

    // Reset during round 5: operation discarded, outputs cleared, no done.
    @(negedge clk);
    start_v[0] = 1'b1;
    din_v[0]   = rand_bits(N0);
    kin_v[0]   = 128'(rand_bits(N0 / 2));
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_ready", 256'(ready_v[0]), 256'd1);
    chk("midrst_data_out", get_dout(0), 256'd0);
    chk("midrst_key_out", 256'(get_kout(0)), 256'd0);
    chk("midrst_done", 256'(done_v[0]), 256'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (guard = 0; guard < 2 * NR0; guard++) begin
      @(posedge clk);
      #1;
      if (done_v[0]) ndone++;
    end
    chk("midrst_no_done", 256'(ndone), 256'd0);
    $display("midrst id=0 stray_dones=%0d", ndone);
    pt = rand_bits(N0);
    k0 = 128'(rand_bits(N0 / 2));
    model_run(N0, NR0, 1'b0, pt, k0, mdout, mkout);
    op(0, 1'b0, pt, k0, dout, kout, lat);
    chk("midrst_fresh_data", dout, mdout);
    chk("midrst_fresh_key", 256'(kout), 256'(mkout));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sea_round_core.md
# sea_round_core

Iterative, parametrised SEA-style Feistel cipher core. It runs NR rounds, one per clock, on an N-bit block with an N/2-bit key and a per-round key schedule. It supports encryption and decryption modes and uses a start/ready/done handshake. It supersedes the single-round combinational datapath and sits between the block buffer and the output formatter.

## Interface
Parameters:
- N, 256, block width in bits; N/2 must be a multiple of B
- B, 8, word width in bits; W = N/(2B) words per half
- NR, 16, round count, 1..255

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when ready=1
- mode  in  1  0 = encrypt, 1 = decrypt; sampled with start
- data_in  in  N  block {L,R}, L = [N-1:N/2]; sampled with start
- key_in  in  N/2  encrypt: K_0; decrypt: K_{NR-1}; sampled with start
- ready  out  1  core idle, start will be accepted
- done  out  1  one-cycle pulse: data_out/key_out valid
- data_out  out  N  result {L,R}, held until next done
- key_out  out  N/2  encrypt: K_{NR-1}; decrypt: K_0

## Operation
- Word j of a half = bits [jB+B-1:jB]. Triple t = words 3t, 3t+1, 3t+2. Words past the last full triple bypass S and BR.
- ADD(R,K): word-wise add mod 2^B, no carry between words.
- S: bitsliced per triple. For bit k, v = {w3t+2[k], w3t+1[k], w3t[k]} is replaced by S[v], S = {0,5,6,7,4,3,1,2}.
- BR: per triple, w3t rotates right by 1 bit, w3t+1 is unchanged, w3t+2 rotates left by 1 bit.
- WR: rotate the half left by B bits (out word j+1 = in word j; out word 0 = in word W-1). WR⁻¹ is the inverse.
- F(R,K) = BR(S(ADD(R,K))).
- Encrypt round i = 0..NR-1:
  - L' = R
  - R' = WR(L ^ F(R,K_i))
  - K_{i+1} = rotl(K_i, B) ^ i, with i zero-extended into the low bits.
- Decrypt round i = NR-1 down to 0:
  - R = L'
  - L = WR⁻¹(R') ^ F(L',K_i)
  - K_{i-1} = rotr(K_i ^ (i-1), B).
- Decrypting with key_in = key_out from encryption returns the original plaintext.
- FSM states:
  - IDLE (ready=1). On start: load block, key and mode, set round counter (enc 0, dec NR-1), go to RUN.
  - RUN: one round per edge. The counter steps up (enc) or down (dec). After the NR-th round, load data_out/key_out, pulse done and go to IDLE.
- key_out is the last key used in a round (enc K_{NR-1}, dec K_0), not the next-step value.
- start while in RUN is ignored; no queuing.
- A mode change during RUN has no effect, because mode is latched at accept.

## Timing
- Reset: ready=1, done=0, data_out=0, key_out=0. FSM goes to IDLE and the counter to 0. An in-flight operation is discarded and done is never pulsed for it.
- start accepted at edge e: ready=0 from e. Rounds execute at edges e+1..e+NR.
- At edge e+NR: data_out/key_out are updated, done=1 for exactly one cycle, ready=1.
- Latency start→done is NR cycles. Throughput is one block per NR+1 cycles for back-to-back use.
- A start in the cycle where done=1 is accepted, because ready=1 at that point.
- data_out/key_out change only at done edges or on reset.
- NR=1: done at e+1.

## Test plan
- Reset, then encrypt with data_in=0, key_in=0, NR=1 -> done one cycle after accept, data_out=0, key_out=0, ready back to 1.
- Encrypt random block/key with NR=16, then decrypt its data_out using key_out -> data_out equals the original plaintext and key_out equals the original key_in. Repeat for 100 random vectors and for N=96, B=8.
- Width boundary: single-word cases with all-ones words -> ADD wraps mod 2^B (0xFF+0x01=0x00) with no carry into the adjacent word, checked against the reference model.
- start pulsed every cycle during RUN -> ignored. Exactly one done, NR cycles after the first accept. The next accept occurs in the done cycle.
- rst asserted mid-RUN (round 5) -> next cycle ready=1, data_out=0, no done. A fresh encrypt then completes correctly.
- Leftover words: N=80, B=8 (W=5, one triple plus 2 bypass words) -> result matches the model, with bypass words skipping S/BR but still being rotated by WR.
